// File: rtl/ball_collider_if.sv
// ball_collider_if: groups the frame/paddle inputs and the ball/score outputs
// of ball_collider so the playfield logic can be bound as one bundle.
// The debug fields expose the FSM state and the current direction bits.
//
// Handshake semantics: there is no valid/ready pair on this block. iFrame is
// a one-cycle strobe that is only accepted while the collider waits for a
// frame; it is dropped, never queued, in any other state. oUpd is a one-cycle
// strobe marking that oBall_x/oBall_y change on the following cycle. oMiss is
// a one-cycle strobe coincident with oUpd. iStart is only accepted while idle.
interface ball_collider_if #(
  parameter int COORD_W = 10
);
  logic               iFrame;
  logic               iStart;
  logic [COORD_W-1:0] iSlider_x;
  logic [COORD_W-1:0] iSlider_y;
  logic [COORD_W-1:0] oBall_x;
  logic [COORD_W-1:0] oBall_y;
  logic [3:0]         oCrash;
  logic [7:0]         oHit_cnt;
  logic               oMiss;
  logic               oUpd;
  logic               oRun;
  logic [1:0]         oDbg_state;
  logic [1:0]         oDbg_dir;

  modport master (
    output iFrame, iStart, iSlider_x, iSlider_y,
    input  oBall_x, oBall_y, oCrash, oHit_cnt, oMiss, oUpd, oRun,
    input  oDbg_state, oDbg_dir
  );

  modport slave (
    input  iFrame, iStart, iSlider_x, iSlider_y,
    output oBall_x, oBall_y, oCrash, oHit_cnt, oMiss, oUpd, oRun,
    output oDbg_state, oDbg_dir
  );
endinterface

// File: rtl/ball_collider.sv
// ball_collider: owns the ball position/direction, evaluates wall and paddle
// contact once per frame, reflects and steps the ball, counts paddle hits.
// Optional feature macro: BALL_MISS_EN (bottom wall loses the ball instead of
// reflecting it; the ball is re-centred and the FSM returns to IDLE).
// oDbg_state = FSM state, oDbg_dir = {dir_x, dir_y} (1 = positive direction).
module ball_collider #(
  parameter int COORD_W  = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int BALL_R   = 10,
  parameter int PAD_HW   = 50,
  parameter int PAD_HH   = 20,
  parameter int SPEED    = 1
) (
  input logic            iClk,
  input logic            iRst,
  ball_collider_if.slave bus
);

  // Two guard bits: one so unsigned coordinates stay positive, one so
  // differences and +/-SPEED steps never wrap.
  localparam int SW = COORD_W + 2;

  localparam logic [COORD_W-1:0] CTR_X = COORD_W'(SCREEN_W / 2);
  localparam logic [COORD_W-1:0] CTR_Y = COORD_W'(SCREEN_H / 2);

  localparam logic signed [SW-1:0] X_MIN  = SW'(BALL_R);
  localparam logic signed [SW-1:0] X_MAX  = SW'(SCREEN_W - BALL_R);
  localparam logic signed [SW-1:0] Y_MIN  = SW'(BALL_R);
  localparam logic signed [SW-1:0] Y_MAX  = SW'(SCREEN_H - BALL_R);
  localparam logic signed [SW-1:0] OVL_X  = SW'(PAD_HW + BALL_R);
  localparam logic signed [SW-1:0] OVL_Y  = SW'(PAD_HH + BALL_R);
  localparam logic signed [SW-1:0] FACE_X = SW'(PAD_HW);
  localparam logic signed [SW-1:0] STEP   = SW'(SPEED);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_DETECT = 2'd2,
    S_UPDATE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] ball_x_q, ball_x_d;
  logic [COORD_W-1:0] ball_y_q, ball_y_d;
  logic [COORD_W-1:0] pad_x_q, pad_x_d;
  logic [COORD_W-1:0] pad_y_q, pad_y_d;
  logic               dir_x_q, dir_x_d;   // 1 = moving right
  logic               dir_y_q, dir_y_d;   // 1 = moving down
  logic [3:0]         crash_q, crash_d;   // {left,right,up,down}
  logic               pad_hit_q, pad_hit_d;
  logic [7:0]         hit_cnt_q, hit_cnt_d;
`ifdef BALL_MISS_EN
  logic               wall_down_q, wall_down_d;
`endif

  // Signed views of the registered ball and latched paddle.
  logic signed [SW-1:0] bx_s, by_s, px_s, py_s;
  logic signed [SW-1:0] dx_s, dy_s, adx_s, ady_s;
  logic [3:0]           wall_flags;
  logic [3:0]           pad_flags;

  // Next position/direction after reflection, stepping and clamping.
  logic                 new_dir_x, new_dir_y;
  logic signed [SW-1:0] nx_s, ny_s;

  // Contact detection: wall flags plus paddle flags that only fire when the
  // ball is moving towards the paddle, so it can never stick to it.
  always_comb begin
    bx_s  = $signed({2'b00, ball_x_q});
    by_s  = $signed({2'b00, ball_y_q});
    px_s  = $signed({2'b00, pad_x_q});
    py_s  = $signed({2'b00, pad_y_q});
    dx_s  = bx_s - px_s;
    dy_s  = by_s - py_s;
    adx_s = dx_s[SW-1] ? -dx_s : dx_s;
    ady_s = dy_s[SW-1] ? -dy_s : dy_s;
    wall_flags = {bx_s <= X_MIN, bx_s >= X_MAX, by_s <= Y_MIN, by_s >= Y_MAX};
    pad_flags  = 4'b0000;
    if (adx_s <= OVL_X && ady_s <= OVL_Y) begin
      if (adx_s <= FACE_X) begin
        if (dir_y_q && by_s < py_s)  pad_flags[0] = 1'b1;
        if (!dir_y_q && by_s > py_s) pad_flags[1] = 1'b1;
      end else begin
        if (dir_x_q && bx_s < px_s)  pad_flags[2] = 1'b1;
        if (!dir_x_q && bx_s > px_s) pad_flags[3] = 1'b1;
      end
    end
  end

  // Reflection from the registered flags, then one step and clamp per axis.
  // Opposing flags on one axis cancel and keep the current direction.
  always_comb begin
    new_dir_x = dir_x_q;
    if (crash_q[3] && !crash_q[2])      new_dir_x = 1'b1;
    else if (crash_q[2] && !crash_q[3]) new_dir_x = 1'b0;
    new_dir_y = dir_y_q;
    if (crash_q[1] && !crash_q[0])      new_dir_y = 1'b1;
    else if (crash_q[0] && !crash_q[1]) new_dir_y = 1'b0;

    nx_s = new_dir_x ? (bx_s + STEP) : (bx_s - STEP);
    if (nx_s < X_MIN)      nx_s = X_MIN;
    else if (nx_s > X_MAX) nx_s = X_MAX;

    ny_s = new_dir_y ? (by_s + STEP) : (by_s - STEP);
    if (ny_s < Y_MIN)      ny_s = Y_MIN;
    else if (ny_s > Y_MAX) ny_s = Y_MAX;
  end

  // FSM next-state and datapath next values.
  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    pad_x_d   = pad_x_q;
    pad_y_d   = pad_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    crash_d   = crash_q;
    pad_hit_d = pad_hit_q;
    hit_cnt_d = hit_cnt_q;
`ifdef BALL_MISS_EN
    wall_down_d = wall_down_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.iStart) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.iFrame) begin
          pad_x_d = bus.iSlider_x;
          pad_y_d = bus.iSlider_y;
          state_d = S_DETECT;
        end
      end
      S_DETECT: begin
        crash_d   = wall_flags | pad_flags;
        pad_hit_d = |pad_flags;
`ifdef BALL_MISS_EN
        wall_down_d = wall_flags[0];
`endif
        state_d   = S_UPDATE;
      end
      S_UPDATE: begin
        ball_x_d = COORD_W'(nx_s);
        ball_y_d = COORD_W'(ny_s);
        dir_x_d  = new_dir_x;
        dir_y_d  = new_dir_y;
        if (pad_hit_q && hit_cnt_q != 8'hFF) hit_cnt_d = hit_cnt_q + 8'd1;
        state_d  = S_WAIT;
`ifdef BALL_MISS_EN
        // Ball lost at the bottom: park it, keep the score, stop the game.
        if (wall_down_q) begin
          ball_x_d  = CTR_X;
          ball_y_d  = CTR_Y;
          dir_x_d   = 1'b1;
          dir_y_d   = 1'b0;
          hit_cnt_d = hit_cnt_q;
          state_d   = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      ball_x_q  <= CTR_X;
      ball_y_q  <= CTR_Y;
      pad_x_q   <= '0;
      pad_y_q   <= '0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b0;
      crash_q   <= 4'b0000;
      pad_hit_q <= 1'b0;
      hit_cnt_q <= 8'd0;
`ifdef BALL_MISS_EN
      wall_down_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      pad_x_q   <= pad_x_d;
      pad_y_q   <= pad_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      crash_q   <= crash_d;
      pad_hit_q <= pad_hit_d;
      hit_cnt_q <= hit_cnt_d;
`ifdef BALL_MISS_EN
      wall_down_q <= wall_down_d;
`endif
    end
  end

  assign bus.oBall_x    = ball_x_q;
  assign bus.oBall_y    = ball_y_q;
  assign bus.oCrash     = crash_q;
  assign bus.oHit_cnt   = hit_cnt_q;
  assign bus.oUpd       = (state_q == S_UPDATE);
  assign bus.oRun       = (state_q != S_IDLE);
  assign bus.oDbg_state = state_q;
  assign bus.oDbg_dir   = {dir_x_q, dir_y_q};
`ifdef BALL_MISS_EN
  assign bus.oMiss      = (state_q == S_UPDATE) && wall_down_q;
`else
  assign bus.oMiss      = 1'b0;
`endif

endmodule
